// File: rtl/test_link_pkg.sv
// Shared definitions for the test-count optical link.
// Frame: SYNC, CNT[15:8], CNT[7:0], CHK as 8N1 UART bytes.
package test_link_pkg;

    localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;
    localparam int         FRAME_BYTES   = 4;
    localparam int         BITS_PER_BYTE = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } frame_state_t;

    function automatic logic [7:0] frame_chk(
        input logic [7:0]  sync,
        input logic [15:0] cnt
    );
        return sync ^ cnt[15:8] ^ cnt[7:0];
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first, idle high.
// A load on the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
    import test_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       byte_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(BITS_PER_BYTE - 3);

    frame_state_t  state;
    frame_state_t  state_nx;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          baud_end;
    logic          accept;

    assign baud_end = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        txd       = 1'b1;
        busy      = 1'b1;
        byte_done = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load) begin
                    accept   = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (baud_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                txd = shreg[bit_idx];
                if (baud_end && bit_idx == BIT_LAST) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
                    byte_done = 1'b1;
                    if (load) begin
                        accept   = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE || baud_end) begin
                baud <= '0;
            end else begin
                baud <= baud + 1'b1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && baud_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (accept) begin
                shreg <= data;
            end
        end
    end

endmodule

// File: rtl/test_cnt_frame_tx.sv
// Sends the 16-bit test count to the master as a 4-byte UART frame.
// Holds the frame sequencer, count snapshot, pending request and last_sent.
module test_cnt_frame_tx
    import test_link_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 40,
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic [15:0] i_cnt,
    input  logic        i_send,
    input  logic        i_auto,
    output logic        o_txd,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

    frame_state_t state;
    frame_state_t state_nx;
    logic [15:0]  snapshot;
    logic [15:0]  last_sent;
    logic [7:0]   chk;
    logic         pending;
    logic [1:0]   byte_idx;
    logic [1:0]   nxt_idx;
    logic [7:0]   nxt_byte;
    logic [7:0]   load_byte;
    logic         start;
    logic         adv;
    logic         load;
    logic         busy_trig;
    logic         byte_done;

    assign nxt_idx = byte_idx + 2'd1;

    always_comb begin
        nxt_byte = SYNC_BYTE;
        unique case (nxt_idx)
            2'd1:    nxt_byte = snapshot[15:8];
            2'd2:    nxt_byte = snapshot[7:0];
            2'd3:    nxt_byte = chk;
            default: nxt_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DONE can restart directly so a pending frame leaves only a 1-cycle gap
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        adv      = 1'b0;
        o_done   = 1'b0;
        case (state)
            IDLE: begin
                if (i_send || pending ||
                    (i_auto && i_cnt != last_sent)) begin
                    start    = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_nx = DONE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (i_send || pending ||
                    (i_auto && i_cnt != snapshot)) begin
                    start    = 1'b1;
                    state_nx = DATA;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign load      = start | adv;
    assign load_byte = start ? SYNC_BYTE : nxt_byte;
    assign busy_trig = (state == DATA) &&
                       (i_send || (i_auto && i_cnt != snapshot));

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            snapshot  <= '0;
            last_sent <= '0;
            chk       <= '0;
            pending   <= 1'b0;
            byte_idx  <= '0;
        end else begin
            if (start) begin
                snapshot <= i_cnt;
                chk      <= frame_chk(SYNC_BYTE, i_cnt);
                pending  <= 1'b0;
                byte_idx <= '0;
            end else begin
                if (busy_trig) begin
                    pending <= 1'b1;
                end
                if (adv) begin
                    byte_idx <= nxt_idx;
                end
            end
            if (state == DONE) begin
                last_sent <= snapshot;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (i_clk),
        .rst_n    (i_res_n),
        .load     (load),
        .data     (load_byte),
        .txd      (o_txd),
        .busy     (o_busy),
        .byte_done(byte_done)
    );

endmodule

// File: tb/tb_test_cnt_frame_tx.sv
// Bench for test_cnt_frame_tx: directed frames, UART monitor and byte scoreboard.
module tb_test_cnt_frame_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 40 * CPB;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        send    = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] cnt     = 16'h0000;
    logic        txd;
    logic        busy;
    logic        done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    test_cnt_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_clk  (clk),
        .i_res_n(rst_n),
        .i_cnt  (cnt),
        .i_send (send),
        .i_auto (auto_en),
        .o_txd  (txd),
        .o_busy (busy),
        .o_done (done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    // Monitor: decode each 8N1 byte mid-bit and score it against the queue
    logic [7:0] mon_sh  = 8'h00;
    int         mon_cnt = 0;
    bit         mon_act = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 2) % 4 == 0) begin
                mon_sh[(mon_cnt - 6) / 4] = txd;
            end
            if (mon_cnt == 38) begin
                check("stop_bit", {31'd0, txd}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_byte: got %0h expected none", mon_sh);
                end else begin
                    check("byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
                end
                mon_act = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_txd"},  {31'd0, txd},  32'd1);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_frame(input string name, input int exp_busy);
        int bc   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < FRAME * 3 && !seen; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                check({name, "_done_txd"},  {31'd0, txd},  32'd1);
                check({name, "_done_busy"}, {31'd0, busy}, 32'd0);
            end
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_busy_len"}, bc, exp_busy);
    endtask

    task automatic gap_check(input string name);
        @(negedge clk);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_txd"},  {31'd0, txd},  32'd0);
    endtask

    task automatic idle_check(input string name, input int n);
        int act = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy || done || !txd) act++;
        end
        check(name, act, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        do_reset("rst");

        // single send
        push4(8'hA5, 8'h12, 8'h34, 8'h83);
        tick();
        cnt  = 16'h1234;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_frame("t1", FRAME);
        idle_check("t1_idle", 50);

        // auto mode from a fresh reset
        do_reset("rst2");
        cnt     = 16'h0000;
        auto_en = 1'b1;
        idle_check("t2_nochg", 30);
        push4(8'hA5, 8'h00, 8'h01, 8'hA4);
        tick();
        cnt = 16'h0001;
        wait_frame("t2", FRAME);
        idle_check("t2_hold", 200);

        // wrap, with send and auto trigger in the same cycle
        push4(8'hA5, 8'hFF, 8'hFF, 8'hA5);
        tick();
        cnt  = 16'hFFFF;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_frame("t4a", FRAME);
        push4(8'hA5, 8'h00, 8'h00, 8'hA5);
        tick();
        cnt = 16'h0000;
        wait_frame("t4b", FRAME);
        idle_check("t4_idle", 100);

        // count changes while busy -> one extra frame with latest value
        push4(8'hA5, 8'h00, 8'h05, 8'hA0);
        push4(8'hA5, 8'h00, 8'h07, 8'hA2);
        tick();
        cnt = 16'h0005;
        fork
            wait_frame("t3a", FRAME);
            begin
                repeat (30) tick();
                cnt = 16'h0006;
                repeat (30) tick();
                cnt = 16'h0007;
            end
        join
        gap_check("t3_gap");
        wait_frame("t3b", FRAME - 1);
        idle_check("t3_idle", 100);

        // reset during the start bit of byte 2
        auto_en = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hAB);
        tick();
        cnt  = 16'hABCD;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (81) @(posedge clk);
        #2;
        check("t5_pre_txd", {31'd0, txd}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_txd",  {31'd0, txd},  32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("t5_q", exp_q.size(), 0);
        idle_check("t5_noresend", 100);
        push4(8'hA5, 8'hAB, 8'hCD, 8'hC3);
        tick();
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_frame("t5b", FRAME);

        // send held high: back-to-back frames, each with its own snapshot
        push4(8'hA5, 8'h01, 8'h02, 8'hA6);
        push4(8'hA5, 8'h03, 8'h04, 8'hA2);
        push4(8'hA5, 8'h05, 8'h06, 8'hA6);
        tick();
        cnt  = 16'h0102;
        send = 1'b1;
        fork
            wait_frame("t6a", FRAME);
            begin
                repeat (50) tick();
                cnt = 16'h0304;
            end
        join
        gap_check("t6_gap1");
        fork
            wait_frame("t6b", FRAME - 1);
            begin
                repeat (20) tick();
                send = 1'b0;
                cnt  = 16'h0506;
            end
        join
        gap_check("t6_gap2");
        wait_frame("t6c", FRAME - 1);
        idle_check("t6_idle", 100);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
